serial_to_parallel_collector: RTL and testbench

Downstream deserializer stage for the 4-bit parallel-to-serial shifter. Samples a qualified serial bit stream (serial + valid), assembles DATA_W-bit words, and presents each completed word on a one-entry registered output with a valid/ready handshake. Backpressure is reported through a sticky overflow flag; the serial side is never stalled.

---
 rtl/serial_to_parallel_collector.sv | 113 +++++++++++
 tb/tb_serial_to_parallel_collector.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel_collector.sv
// Serial-to-parallel collector: assembles DATA_W-bit words from a qualified bit
// stream and hands them off through a one-entry valid/ready holding register.
module serial_to_parallel_collector #(
    parameter int unsigned DATA_W    = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] parallel_o,
    output logic              parallel_valid_o,
    input  logic              parallel_ready_i,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    if (DATA_W < 2 || DATA_W > 16) begin : g_bad_width
        $error("serial_to_parallel_collector: DATA_W must be 2..16");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    hold_state_t       state, state_next;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] word_next;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              complete;
    logic              drain;
    logic              load;
    logic              drop;

    // Word as it will look once the current bit is shifted in.
    if (LSB_FIRST) begin : g_lsb
        assign word_next = {serial_i, shift_q[DATA_W-1:1]};
    end else begin : g_msb
        assign word_next = {shift_q[DATA_W-2:0], serial_i};
    end

    assign complete   = valid_i && (count_q == LAST);
    assign count_next = (count_q == LAST) ? '0 : count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
            busy_o  <= 1'b0;
        end else if (valid_i) begin
            shift_q <= word_next;
            count_q <= count_next;
            busy_o  <= (count_next != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        drop       = 1'b0;
        drain      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (complete) begin
                    load       = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                drain = parallel_ready_i;
                // A drain in the same cycle frees the slot for the new word.
                if (complete && drain) begin
                    load = 1'b1;
                end else if (complete) begin
                    drop = 1'b1;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_o <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (load) begin
                parallel_o <= word_next;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    assign parallel_valid_o = (state == FULL);

endmodule

// File: tb/tb_serial_to_parallel_collector.sv
// Randomized bench for serial_to_parallel_collector: two instances (4-bit LSB-first,
// 8-bit MSB-first) share stimulus and are compared against a word-level model.
module tb_serial_to_parallel_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready = 1'b0;

    logic [3:0] par4;
    logic       pv4, busy4, ovf4;
    logic [7:0] par8;
    logic       pv8, busy8, ovf8;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state, index 0 = 4-bit LSB-first, 1 = 8-bit MSB-first
    int unsigned m_width[2] = '{4, 8};
    bit          m_lsb[2]   = '{1'b1, 1'b0};
    int unsigned m_nbits[2];
    int unsigned m_acc[2];
    int unsigned m_word[2];
    bit          m_valid[2];
    bit          m_ovf[2];

    always #5 clk = ~clk;

    serial_to_parallel_collector #(.DATA_W(4), .LSB_FIRST(1'b1)) u_dut4 (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(par4), .parallel_valid_o(pv4), .parallel_ready_i(ready),
        .busy_o(busy4), .overflow_o(ovf4)
    );

    serial_to_parallel_collector #(.DATA_W(8), .LSB_FIRST(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(par8), .parallel_valid_o(pv8), .parallel_ready_i(ready),
        .busy_o(busy8), .overflow_o(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit v, input bit s, input bit rdy);
        for (int d = 0; d < 2; d++) begin
            bit          done;
            bit          drain;
            int unsigned word;
            done = 1'b0;
            word = 0;
            if (r) begin
                m_nbits[d] = 0;
                m_acc[d]   = 0;
                m_word[d]  = 0;
                m_valid[d] = 1'b0;
                m_ovf[d]   = 1'b0;
                continue;
            end
            if (v) begin
                if (m_lsb[d]) m_acc[d] = m_acc[d] + (int'(s) << m_nbits[d]);
                else          m_acc[d] = m_acc[d] * 2 + int'(s);
                m_nbits[d]++;
                if (m_nbits[d] == m_width[d]) begin
                    done       = 1'b1;
                    word       = m_acc[d];
                    m_nbits[d] = 0;
                    m_acc[d]   = 0;
                end
            end
            drain = m_valid[d] && rdy;
            if (done) begin
                if (!m_valid[d] || drain) begin
                    m_word[d]  = word;
                    m_valid[d] = 1'b1;
                end else begin
                    m_ovf[d] = 1'b1;
                end
            end else if (drain) begin
                m_valid[d] = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        check("w4.parallel_o", 32'(par4),  m_word[0]);
        check("w4.valid",      32'(pv4),   32'(m_valid[0]));
        check("w4.busy",       32'(busy4), 32'(m_nbits[0] != 0));
        check("w4.overflow",   32'(ovf4),  32'(m_ovf[0]));
        check("w8.parallel_o", 32'(par8),  m_word[1]);
        check("w8.valid",      32'(pv8),   32'(m_valid[1]));
        check("w8.busy",       32'(busy8), 32'(m_nbits[1] != 0));
        check("w8.overflow",   32'(ovf8),  32'(m_ovf[1]));
    endtask

    task automatic step(input bit r, input bit v, input bit s, input bit rdy);
        reset    = r;
        valid_i  = v;
        serial_i = s;
        ready    = rdy;
        @(posedge clk);
        model_step(r, v, s, rdy);
        #1;
        compare_all();
    endtask

    task automatic send_word4(input logic [3:0] w, input int unsigned gap, input bit rdy);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, w[i], rdy);
            for (int g = 0; g < int'(gap); g++) step(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    initial begin
        logic [3:0] wb;
        logic [3:0] w6;
        logic [3:0] wc;
        logic [7:0] wa5;
        wb  = 4'hB;
        w6  = 4'h6;
        wc  = 4'hC;
        wa5 = 8'hA5;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset.valid", 32'(pv4), 32'd0);
        check("reset.par",   32'(par4), 32'd0);

        // Single word, ready held high; busy after bits 1..3
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, wb[i], 1'b1);
            check("single.busy", 32'(busy4), (i < 3) ? 32'd1 : 32'd0);
        end
        check("single.par",   32'(par4), 32'hB);
        check("single.valid", 32'(pv4),  32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("single.drop",  32'(pv4),  32'd0);

        // Gapped input
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word4(wb, 3, 1'b1);
        // The last bit has 3 gap cycles after it; valid must have pulsed once and drained
        check("gap.par", 32'(par4), 32'hB);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, wb[i], 1'b0);
        check("gapless.par", 32'(par4), 32'hB);

        // Backpressure: second word dropped
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w6[i], 1'b0);
        check("ovf.par",   32'(par4), 32'hB);
        check("ovf.valid", 32'(pv4),  32'd1);
        check("ovf.flag",  32'(ovf4), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf.drain_valid", 32'(pv4),  32'd0);
        check("ovf.sticky",      32'(ovf4), 32'd1);

        // Simultaneous drain and completion
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, wb[i], 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w6[i], (i == 3));
        check("sim.par",   32'(par4), 32'h6);
        check("sim.valid", 32'(pv4),  32'd1);
        check("sim.ovf",   32'(ovf4), 32'd0);

        // Reset mid-word
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst.busy", 32'(busy4), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, wc[i], 1'b1);
        check("midrst.par", 32'(par4), 32'hC);

        // MSB-first 8-bit: first bit lands in the top bit
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, wa5[i], 1'b1);
        check("msb.par",   32'(par8), 32'hA5);
        check("msb.valid", 32'(pv8),  32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                 1'($urandom), ($urandom_range(0, 9) < 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
